memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Memory-access (MA) stage of the pipeline and the consumer of the execute stage's result and memory-control outputs. It holds the EX/MA pipeline register and drives the data-memory request/acknowledge bus. It aligns store data, generates byte enables, and sign- or zero-extends load data. It stalls upstream while an access is outstanding and registers the selected write-back value into the MA/WB register.

## Interface
- DATA_SIZE, 32, data and address width
- INST_SIZE, 32, PC width
- NUM_REGS, 32, register count; destination width is clog2(NUM_REGS)
- ACK_TIMEOUT, 255, maximum BUSY cycles without ack (only with MA_ACK_TIMEOUT_EN)
- Reset: one clock; reset is synchronous and active-high.
- i_aclk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_en  in  1  incoming EX instruction valid; low captures a bubble
- i_exe_calc, i_exe_wdata  in  DATA_SIZE  ALU result/address, store data
- i_pcplus4  in  INST_SIZE  link value
- i_rdest  in  clog2(NUM_REGS)  write-back destination
- i_cu_regwrite, i_cu_memwrite, i_cu_memaccess  in  1  control bits
- i_cu_memtoreg  in  2  00 ALU, 01 memory, 10 pcplus4
- i_ldop  in  3  funct3 encoding: LB 000, LH 001, LW 010, LBU 100, LHU 101
- i_sop  in  2  SB 00, SH 01, SW 10
- o_stall  out  1  holds the EX stage and all upstream stages
- o_ma_op  out  DATA_SIZE  stage calc value, used for forwarding
- o_ma_rdest / o_ma_regwrite  out  clog2(NUM_REGS)/1  stage destination and write enable, for the hazard unit
- o_dmem_req, o_dmem_we  out  1  request, write
- o_dmem_addr  out  DATA_SIZE  word-aligned address {calc[31:2],2'b00}
- o_dmem_wdata  out  DATA_SIZE  lane-replicated store data
- o_dmem_be  out  4  byte enables (0000 on reads)
- i_dmem_ack  in  1  access complete; read data valid in the same cycle
- i_dmem_rdata  in  DATA_SIZE  read word
- o_wb_data  out  DATA_SIZE  registered write-back value
- o_wb_rdest  out  clog2(NUM_REGS)  registered destination
- o_wb_regwrite  out  1  registered write enable
- o_misaligned, o_bus_err  out  1  one-cycle fault pulses, registered with WB

## Operation
- The stage register captures all inputs on each edge where o_stall=0.
  - With i_en=0, the control bits (regwrite, memwrite, memaccess) are captured as 0.
- Misaligned access:
  - halfword with addr[0]=1
  - word with addr[1:0]≠00
  - No request is issued. WB regwrite is forced to 0 and o_misaligned pulses with the WB update.
- FSM IDLE/BUSY; the next state is computed only on advancing edges.
  - Next state is BUSY if the captured instruction is valid, has memaccess=1 and is aligned; otherwise IDLE.
- In BUSY:
  - o_dmem_req=1; addr, we, be and wdata are held stable.
  - done = i_dmem_ack | timeout.
  - o_stall = BUSY & ~done.
- In IDLE, i_dmem_ack is ignored and o_stall=0.
- Store byte enables and data:
  - SB: be=0001<<addr[1:0], byte replicated ×4.
  - SH: be=0011<<{addr[1],1'b0}, half replicated ×2.
  - SW: be=1111.
- Load formatting: select the byte or half from i_dmem_rdata by addr; sign-extend for LB/LH, zero-extend for LBU/LHU.
- WB register:
  - Captures on advancing edges: data selected by memtoreg, stage rdest, and regwrite.
  - regwrite is cleared on misalignment or bus error.
  - On stalled edges it captures a bubble (regwrite=0).
- memtoreg=11 is illegal; o_wb_data is 0 in that case.

## Timing
- Reset values:
  - state IDLE
  - all stage control bits 0
  - o_stall, o_dmem_req, o_dmem_we 0; o_dmem_be 0000
  - o_wb_data, o_wb_rdest, o_wb_regwrite 0
  - o_misaligned, o_bus_err 0
  - timeout counter 0
- Non-memory ops: captured at edge N, WB valid after edge N+1, no stall.
- Access captured at edge N: the request is visible in cycle N.
  - Ack in cycle N+k gives k stall cycles; WB is valid after edge N+k+1.
  - Zero-wait ack (k=0) gives no stall.
- The next instruction is captured on the same edge as the completing ack, so back-to-back accesses leave no idle cycle.
- Reset while BUSY: request drops after the reset edge; any later ack is ignored.
- A new request is never issued before the previous ack.

## Configuration
- MA_ACK_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments on each BUSY cycle without ack.
  - When the ACK_TIMEOUT-th BUSY cycle passes without ack, the unit aborts as done, o_bus_err pulses, and WB regwrite=0.
  - An ack in that same cycle wins and no error is raised.
- MA_ACK_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; o_bus_err is tied 0.

## Test plan
- LB, calc=0x1003, rdata=0x80FF_FF7F, ack after 2 cycles -> 2 stall cycles, req addr 0x1000, o_wb_data=0xFFFF_FF80, regwrite=1.
- SH, calc=0x2002, wdata=0x0000_ABCD, zero-wait ack -> be=1100, o_dmem_wdata=0xABCD_ABCD, we=1, no stall, WB regwrite=0.
- LW, calc=0x2001 -> no req, o_misaligned pulses, o_wb_regwrite=0.
- ALU op (memtoreg=00, calc=5) followed by JAL-link op (memtoreg=10, pcplus4=0x44) -> consecutive WB values 5 then 0x44, no stalls.
- Assert i_reset in BUSY, then ack one cycle later -> req=0 after the reset edge, ack ignored, all outputs at reset values.
- With MA_ACK_TIMEOUT_EN and ACK_TIMEOUT=4, no ack -> 3 stall cycles, o_bus_err pulses, WB regwrite=0; without the macro, stall persists.

Source files
------------

// File: rtl/memory_access_unit_if.sv
// Data-memory request/acknowledge bus between the MA stage and data memory.
interface memory_access_unit_if #(
  parameter int DATA_SIZE = 32
);
  logic                 req;
  logic                 we;
  logic [DATA_SIZE-1:0] addr;
  logic [DATA_SIZE-1:0] wdata;
  logic [3:0]           be;
  logic                 ack;
  logic [DATA_SIZE-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: EX/MA register, data-memory bus master,
// store lane alignment, load extraction/extension, MA/WB register.
// Optional macro MA_ACK_TIMEOUT_EN: abort a BUSY access after ACK_TIMEOUT
// cycles without ack and raise o_bus_err.
module memory_access_unit #(
  parameter int DATA_SIZE   = 32,
  parameter int INST_SIZE   = 32,
  parameter int NUM_REGS    = 32,
  parameter int ACK_TIMEOUT = 255,
  localparam int RW         = $clog2(NUM_REGS)
) (
  input  logic                 i_aclk,
  input  logic                 i_reset,
  input  logic                 i_en,
  input  logic [DATA_SIZE-1:0] i_exe_calc,
  input  logic [DATA_SIZE-1:0] i_exe_wdata,
  input  logic [INST_SIZE-1:0] i_pcplus4,
  input  logic [RW-1:0]        i_rdest,
  input  logic                 i_cu_regwrite,
  input  logic                 i_cu_memwrite,
  input  logic                 i_cu_memaccess,
  input  logic [1:0]           i_cu_memtoreg,
  input  logic [2:0]           i_ldop,
  input  logic [1:0]           i_sop,
  output logic                 o_stall,
  output logic [DATA_SIZE-1:0] o_ma_op,
  output logic [RW-1:0]        o_ma_rdest,
  output logic                 o_ma_regwrite,
  memory_access_unit_if.master dmem,
  output logic [DATA_SIZE-1:0] o_wb_data,
  output logic [RW-1:0]        o_wb_rdest,
  output logic                 o_wb_regwrite,
  output logic                 o_misaligned,
  output logic                 o_bus_err
);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [DATA_SIZE-1:0] calc;
    logic [DATA_SIZE-1:0] wdata;
    logic [INST_SIZE-1:0] pc4;
    logic [RW-1:0]        rdest;
    logic                 regwrite;
    logic                 memwrite;
    logic                 memaccess;
    logic [1:0]           memtoreg;
    logic [2:0]           ldop;
    logic [1:0]           sop;
  } stage_t;

  stage_t               st, st_d;
  state_e               state, state_nxt;
  logic                 adv, done, tmo, berr, mis, in_go;
  logic [3:0]           be_st;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [DATA_SIZE-1:0] ld_data, wd_rep, wb_sel;

  // Size code shared by loads (funct3[1:0]) and stores (sop): 00 byte, 01 half, 10 word.
  function automatic logic misal(logic [1:0] a, logic wr, logic [2:0] ld, logic [1:0] so);
    logic [1:0] sz;
    sz = wr ? so : ld[1:0];
    return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a != 2'b00);
  endfunction

  // Incoming instruction will start a bus access once captured.
  assign in_go = i_en & i_cu_memaccess & ~misal(i_exe_calc[1:0], i_cu_memwrite, i_ldop, i_sop);
  // Captured instruction is a faulting access (controls already masked for bubbles).
  assign mis   = st.memaccess & misal(st.calc[1:0], st.memwrite, st.ldop, st.sop);
  assign adv   = ~o_stall;
  assign berr  = tmo & ~dmem.ack;

`ifdef MA_ACK_TIMEOUT_EN
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  logic [CW-1:0] tcnt;

  // Count BUSY cycles without ack; cleared on every advancing edge (entry to BUSY included).
  always_ff @(posedge i_aclk) begin
    if (i_reset)                        tcnt <= '0;
    else if (adv)                       tcnt <= '0;
    else if (state == BUSY && !dmem.ack) tcnt <= tcnt + 1'b1;
  end

  assign tmo = (state == BUSY) && (tcnt == CW'(ACK_TIMEOUT - 1));
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = |ACK_TIMEOUT;
  assign tmo = 1'b0;
`endif

  // Next stage contents; a bubble clears all control bits.
  always_comb begin
    st_d           = '0;
    st_d.calc      = i_exe_calc;
    st_d.wdata     = i_exe_wdata;
    st_d.pc4       = i_pcplus4;
    st_d.rdest     = i_rdest;
    st_d.memtoreg  = i_cu_memtoreg;
    st_d.ldop      = i_ldop;
    st_d.sop       = i_sop;
    st_d.regwrite  = i_en & i_cu_regwrite;
    st_d.memwrite  = i_en & i_cu_memwrite;
    st_d.memaccess = i_en & i_cu_memaccess;
  end

  // State register.
  always_ff @(posedge i_aclk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and stall; the next state follows the instruction captured on an advancing edge.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    o_stall   = 1'b0;
    case (state)
      IDLE: state_nxt = in_go ? BUSY : IDLE;
      BUSY: begin
        done    = dmem.ack | tmo;
        o_stall = ~done;
        if (done) state_nxt = in_go ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // EX/MA stage register, held while stalled so the bus stays stable.
  always_ff @(posedge i_aclk) begin
    if (i_reset)  st <= '0;
    else if (adv) st <= st_d;
  end

  // Store byte enables and lane-replicated store data.
  always_comb begin
    be_st  = 4'b1111;
    wd_rep = st.wdata;
    case (st.sop)
      2'b00: begin
        be_st  = 4'b0001 << st.calc[1:0];
        wd_rep = {(DATA_SIZE/8){st.wdata[7:0]}};
      end
      2'b01: begin
        be_st  = 4'b0011 << {st.calc[1], 1'b0};
        wd_rep = {(DATA_SIZE/16){st.wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem.req   = (state == BUSY);
  assign dmem.we    = dmem.req & st.memwrite;
  assign dmem.be    = dmem.we ? be_st : 4'b0000;
  assign dmem.addr  = {st.calc[DATA_SIZE-1:2], 2'b00};
  assign dmem.wdata = wd_rep;

  // Load lane extraction and sign/zero extension.
  always_comb begin
    byte_sel = dmem.rdata[{st.calc[1:0], 3'b000} +: 8];
    half_sel = dmem.rdata[{st.calc[1], 4'b0000} +: 16];
    ld_data  = dmem.rdata;
    case (st.ldop)
      3'b000:  ld_data = {{(DATA_SIZE-8){byte_sel[7]}}, byte_sel};
      3'b001:  ld_data = {{(DATA_SIZE-16){half_sel[15]}}, half_sel};
      3'b100:  ld_data = {{(DATA_SIZE-8){1'b0}}, byte_sel};
      3'b101:  ld_data = {{(DATA_SIZE-16){1'b0}}, half_sel};
      default: ;
    endcase
  end

  // Write-back source select; 11 is illegal and yields zero.
  always_comb begin
    wb_sel = '0;
    case (st.memtoreg)
      2'b00:   wb_sel = st.calc;
      2'b01:   wb_sel = ld_data;
      2'b10:   wb_sel = DATA_SIZE'(st.pc4);
      default: ;
    endcase
  end

  // MA/WB register; stalled edges insert a bubble, faults suppress the write.
  always_ff @(posedge i_aclk) begin
    if (i_reset) begin
      o_wb_data     <= '0;
      o_wb_rdest    <= '0;
      o_wb_regwrite <= 1'b0;
      o_misaligned  <= 1'b0;
      o_bus_err     <= 1'b0;
    end else if (adv) begin
      o_wb_data     <= wb_sel;
      o_wb_rdest    <= st.rdest;
      o_wb_regwrite <= st.regwrite & ~mis & ~berr;
      o_misaligned  <= mis;
      o_bus_err     <= berr;
    end else begin
      o_wb_regwrite <= 1'b0;
      o_misaligned  <= 1'b0;
      o_bus_err     <= 1'b0;
    end
  end

  assign o_ma_op       = st.calc;
  assign o_ma_rdest    = st.rdest;
  assign o_ma_regwrite = st.regwrite;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: per-cycle vector table plus hand
// sequences for timeout/indefinite stall and reset during an access.
module tb_memory_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        en, rw, mw, ma;
  logic [31:0] calc, wdata, pc4;
  logic [4:0]  rdest;
  logic [1:0]  m2r, sop;
  logic [2:0]  ldop;
  logic        stall, ma_rw, wb_rw, mis, berr;
  logic [31:0] ma_op, wb_data;
  logic [4:0]  ma_rd, wb_rd;

  always #5 clk = ~clk;

  memory_access_unit_if #(.DATA_SIZE(32)) dmem ();

  memory_access_unit #(.ACK_TIMEOUT(4)) dut (
    .i_aclk(clk), .i_reset(rst), .i_en(en),
    .i_exe_calc(calc), .i_exe_wdata(wdata), .i_pcplus4(pc4), .i_rdest(rdest),
    .i_cu_regwrite(rw), .i_cu_memwrite(mw), .i_cu_memaccess(ma),
    .i_cu_memtoreg(m2r), .i_ldop(ldop), .i_sop(sop),
    .o_stall(stall), .o_ma_op(ma_op), .o_ma_rdest(ma_rd), .o_ma_regwrite(ma_rw),
    .dmem(dmem),
    .o_wb_data(wb_data), .o_wb_rdest(wb_rd), .o_wb_regwrite(wb_rw),
    .o_misaligned(mis), .o_bus_err(berr)
  );

  typedef struct packed {
    logic        en;
    logic [31:0] calc, wdata, pc4;
    logic [4:0]  rdest;
    logic        rw, mw, ma;
    logic [1:0]  m2r;
    logic [2:0]  ldop;
    logic [1:0]  sop;
  } in_t;

  typedef struct {
    in_t         in;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we;
    logic [3:0]  be;
    logic [31:0] addr, dwd;
    logic        wbrw;
    logic [31:0] wbd;
    logic [4:0]  wbr;
    logic        mis;
  } vec_t;

  vec_t tv[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic in_t nop();
    in_t r = '0;
    return r;
  endfunction

  function automatic in_t alu(logic [31:0] c, logic [1:0] sel, logic [31:0] p, logic [4:0] rd);
    in_t r = '0;
    r.en = 1'b1; r.calc = c; r.m2r = sel; r.pc4 = p; r.rdest = rd; r.rw = 1'b1;
    return r;
  endfunction

  function automatic in_t ld(logic [31:0] c, logic [2:0] op, logic [4:0] rd);
    in_t r = '0;
    r.en = 1'b1; r.calc = c; r.ldop = op; r.rdest = rd; r.rw = 1'b1; r.ma = 1'b1; r.m2r = 2'b01;
    return r;
  endfunction

  function automatic in_t sto(logic [31:0] c, logic [31:0] d, logic [1:0] op);
    in_t r = '0;
    r.en = 1'b1; r.calc = c; r.wdata = d; r.sop = op; r.ma = 1'b1; r.mw = 1'b1;
    return r;
  endfunction

  task automatic add(in_t x, logic a, logic [31:0] rd, logic s, logic rq, logic w,
                     logic [3:0] b, logic [31:0] ad, logic [31:0] dw,
                     logic wr, logic [31:0] wd, logic [4:0] wrd, logic m);
    vec_t v;
    v.in = x; v.ack = a; v.rdata = rd; v.stall = s; v.req = rq; v.we = w; v.be = b;
    v.addr = ad; v.dwd = dw; v.wbrw = wr; v.wbd = wd; v.wbr = wrd; v.mis = m;
    tv.push_back(v);
  endtask

  task automatic drive(in_t x);
    en = x.en; calc = x.calc; wdata = x.wdata; pc4 = x.pc4; rdest = x.rdest;
    rw = x.rw; mw = x.mw; ma = x.ma; m2r = x.m2r; ldop = x.ldop; sop = x.sop;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t bub, alu5, jal;
    int  cnt;

    alu5 = alu(32'd5, 2'b00, 32'h0, 5'd6);
    jal  = alu(32'h99, 2'b10, 32'h44, 5'd7);
    bub  = sto(32'h3000, 32'h0, 2'b10);
    bub.en = 1'b0;

    //  inputs                       ack  rdata          stl rq we be       addr          dwd           wbrw wbd           wbr   mis
    add(ld(32'h1003, 3'b000, 5'd5),  0, 32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        5'd0,  0);
    add(alu5,                        0, 32'h0,          1, 1, 0, 4'b0000, 32'h1000,     32'h0,        0, 32'h0,        5'd0,  0);
    add(alu5,                        0, 32'h0,          1, 1, 0, 4'b0000, 32'h1000,     32'h0,        0, 32'h0,        5'd0,  0);
    add(alu5,                        1, 32'h80FF_FF7F,  0, 1, 0, 4'b0000, 32'h1000,     32'h0,        0, 32'h0,        5'd0,  0);
    add(jal,                         0, 32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 32'hFFFF_FF80, 5'd5,  0);
    add(sto(32'h2002, 32'hABCD, 2'b01), 0, 32'h0,       0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 32'd5,        5'd6,  0);
    add(ld(32'h2001, 3'b010, 5'd8),  1, 32'h0,          0, 1, 1, 4'b1100, 32'h2000,     32'hABCD_ABCD, 1, 32'h44,       5'd7,  0);
    add(bub,                         0, 32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        5'd0,  0);
    add(sto(32'h3001, 32'h1234_5677, 2'b00), 1, 32'h0,  0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        5'd0,  1);
    add(ld(32'h4002, 3'b101, 5'd9),  1, 32'h0,          0, 1, 1, 4'b0010, 32'h3000,     32'h7777_7777, 0, 32'h0,        5'd0,  0);
    add(ld(32'h5002, 3'b001, 5'd10), 1, 32'h8001_7FFF,  0, 1, 0, 4'b0000, 32'h4000,     32'h0,        0, 32'h0,        5'd0,  0);
    add(nop(),                       1, 32'hF00D_1234,  0, 1, 0, 4'b0000, 32'h5000,     32'h0,        1, 32'h0000_8001, 5'd9,  0);
    add(sto(32'h6000, 32'hDEAD_BEEF, 2'b10), 0, 32'h0,  0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 32'hFFFF_F00D, 5'd10, 0);
    add(nop(),                       0, 32'h0,          1, 1, 1, 4'b1111, 32'h6000,     32'hDEAD_BEEF, 0, 32'h0,        5'd0,  0);
    add(nop(),                       1, 32'h0,          0, 1, 1, 4'b1111, 32'h6000,     32'hDEAD_BEEF, 0, 32'h0,        5'd0,  0);
    add(nop(),                       0, 32'h0,          0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 32'h0,        5'd0,  0);

    // Reset state
    rst = 1'b1;
    drive(nop());
    dmem.ack = 1'b0; dmem.rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst stall",    32'(stall),        32'h0);
    chk("rst req",      32'(dmem.req),     32'h0);
    chk("rst we",       32'(dmem.we),      32'h0);
    chk("rst be",       32'(dmem.be),      32'h0);
    chk("rst wb_data",  wb_data,           32'h0);
    chk("rst wb_rdest", 32'(wb_rd),        32'h0);
    chk("rst wb_rw",    32'(wb_rw),        32'h0);
    chk("rst mis",      32'(mis),          32'h0);
    chk("rst berr",     32'(berr),         32'h0);
    chk("rst ma_rw",    32'(ma_rw),        32'h0);
    rst = 1'b0;

    // Vector table, one entry per cycle
    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].in);
      dmem.ack = tv[i].ack; dmem.rdata = tv[i].rdata;
      #1;
      chk($sformatf("v%0d stall", i), 32'(stall),    32'(tv[i].stall));
      chk($sformatf("v%0d req", i),   32'(dmem.req), 32'(tv[i].req));
      chk($sformatf("v%0d wb_rw", i), 32'(wb_rw),    32'(tv[i].wbrw));
      chk($sformatf("v%0d mis", i),   32'(mis),      32'(tv[i].mis));
      chk($sformatf("v%0d berr", i),  32'(berr),     32'h0);
      if (tv[i].req) begin
        chk($sformatf("v%0d we", i),   32'(dmem.we), 32'(tv[i].we));
        chk($sformatf("v%0d be", i),   32'(dmem.be), 32'(tv[i].be));
        chk($sformatf("v%0d addr", i), dmem.addr,    tv[i].addr);
        if (tv[i].we) chk($sformatf("v%0d dwdata", i), dmem.wdata, tv[i].dwd);
      end
      if (tv[i].wbrw) begin
        chk($sformatf("v%0d wb_data", i),  wb_data,    tv[i].wbd);
        chk($sformatf("v%0d wb_rdest", i), 32'(wb_rd), 32'(tv[i].wbr));
      end
    end

    // Access that never gets an ack
    @(negedge clk);
    drive(ld(32'h7000, 3'b010, 5'd11));
    dmem.ack = 1'b0; dmem.rdata = 32'h1122_3344;
    @(negedge clk);
    drive(nop());
    #1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (!stall) break;
      cnt++;
      @(negedge clk); #1;
    end
`ifdef MA_ACK_TIMEOUT_EN
    chk("tmo stall cycles", 32'(cnt), 32'd3);
    @(negedge clk); #1;
    chk("tmo berr",  32'(berr),     32'h1);
    chk("tmo wb_rw", 32'(wb_rw),    32'h0);
    chk("tmo req",   32'(dmem.req), 32'h0);
    @(negedge clk); #1;
    chk("tmo berr pulse", 32'(berr), 32'h0);
`else
    chk("noack stall persists", 32'(cnt), 32'd10);
    dmem.ack = 1'b1;
    #1;
    chk("noack release stall", 32'(stall), 32'h0);
    @(negedge clk);
    dmem.ack = 1'b0;
    #1;
    chk("noack wb_rw",    32'(wb_rw), 32'h1);
    chk("noack wb_data",  wb_data,    32'h1122_3344);
    chk("noack wb_rdest", 32'(wb_rd), 32'd11);
    chk("noack berr",     32'(berr),  32'h0);
`endif

    // Reset while BUSY, ack arriving one cycle after the reset edge
    @(negedge clk);
    drive(ld(32'h8000, 3'b010, 5'd12));
    dmem.ack = 1'b0;
    @(negedge clk);
    drive(nop());
    #1;
    chk("rb req",      32'(dmem.req), 32'h1);
    chk("rb stall",    32'(stall),    32'h1);
    chk("rb ma_op",    ma_op,         32'h8000);
    chk("rb ma_rdest", 32'(ma_rd),    32'd12);
    chk("rb ma_rw",    32'(ma_rw),    32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem.ack = 1'b1; dmem.rdata = 32'h55;
    #1;
    chk("rb req after rst",   32'(dmem.req), 32'h0);
    chk("rb stall after rst", 32'(stall),    32'h0);
    chk("rb ma_rw after rst", 32'(ma_rw),    32'h0);
    @(negedge clk);
    dmem.ack = 1'b0;
    #1;
    chk("rb wb_rw",    32'(wb_rw),    32'h0);
    chk("rb wb_data",  wb_data,       32'h0);
    chk("rb wb_rdest", 32'(wb_rd),    32'h0);
    chk("rb mis",      32'(mis),      32'h0);
    chk("rb berr",     32'(berr),     32'h0);
    chk("rb req idle", 32'(dmem.req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
